// File: rtl/alu.sv
// alu: add/sub/mul/div on WIDTH-bit unsigned operands, with status flags for each result.
// Latency: exactly 1 cycle. A, B and ALUControl are sampled at a rising edge and appear on the outputs after that edge.
// Backpressure: none. A new operation is accepted every cycle and the block never stalls.
//
// Ports:
//   clk        - single clock; all state changes on its rising edge
//   rst_n      - synchronous active-low reset. It takes priority over any operation at the same edge.
//   A, B       - operands (WIDTH bits)
//   ALUControl - operation select: 00 add, 01 sub, 10 mul, 11 div
//   Result     - registered result (WIDTH bits)
//   OverFlow   - registered flag:
//                  add/sub: signed overflow
//                  mul: product did not fit in WIDTH bits
//                  div: divide by zero
//   Carry      - registered flag:
//                  add: carry out
//                  sub: no borrow (A >= B)
//                  mul/div: 0
//   Zero       - registered flag, Result == 0
//   Negative   - registered copy of Result[WIDTH-1]
module alu #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             OverFlow,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Datapath: every operation is computed in parallel; ALUControl only steers the result.
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic               div_by_zero;

  // One guard bit on the operands.
  // For add, the guard bit is the carry out. For sub, it is the borrow.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign div_by_zero = (B == '0);

  // Divide-by-zero is steered to all ones, so the divider output never leaks X.
  always_comb begin
    quot = '1;
    if (!div_by_zero) begin
      quot = A / B;
    end
  end

  logic [WIDTH-1:0] result_d, result_q;
  logic             ovf_d, ovf_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    carry_d  = 1'b0;
    unique case (ALUControl)
      OP_ADD: begin
        result_d = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
        // Signed overflow: the operands have the same sign and the result sign differs.
        ovf_d    = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = diff_ext[WIDTH-1:0];
        // A borrow into the guard bit means A < B unsigned.
        carry_d  = ~diff_ext[WIDTH];
        // Signed overflow: the operand signs differ and the result sign differs from A.
        ovf_d    = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: begin
        result_d = prod[WIDTH-1:0];
        ovf_d    = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        result_d = quot;
        ovf_d    = div_by_zero;
      end
      default: begin
        result_d = '0;
      end
    endcase
    // Flags derive from the final result, so divide-by-zero reports Negative=1 and Zero=0.
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign Result   = result_q;
  assign OverFlow = ovf_q;
  assign Carry    = carry_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: bench for alu (WIDTH = 34).
// Compares a packed status vector {Result, OverFlow, Carry, Zero, Negative} against fixed
// expected values and against an arithmetic reference model, sampling #1 after each rising edge.
module tb_alu;

  localparam int W = 34;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   ALUControl;
  logic [W-1:0] Result;
  logic         OverFlow;
  logic         Carry;
  logic         Zero;
  logic         Negative;

  int checks;
  int failures;

  alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .Result     (Result),
    .OverFlow   (OverFlow),
    .Carry      (Carry),
    .Zero       (Zero),
    .Negative   (Negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the observed outputs: {Result, OverFlow, Carry, Zero, Negative}.
  function automatic logic [W+3:0] observed();
    return {Result, OverFlow, Carry, Zero, Negative};
  endfunction

  // Reference model.
  // Works on whole-number values: signed overflow is a range check on the true sum or difference.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    longint       m;
    longint       ua;
    longint       ub;
    longint       sa;
    longint       sb;
    longint       t;
    longint       st;
    logic [2*W-1:0] p;
    logic [W-1:0] res;
    logic         ovf;
    logic         cy;

    m   = longint'(1) << W;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[W-1] ? ua - m : ua;
    sb  = b[W-1] ? ub - m : ub;
    res = '0;
    ovf = 1'b0;
    cy  = 1'b0;

    case (op)
      2'b00: begin
        t   = ua + ub;
        res = t[W-1:0];
        cy  = (t >= m);
        st  = sa + sb;
        ovf = (st > m / 2 - 1) || (st < -(m / 2));
      end
      2'b01: begin
        t   = ua - ub;
        res = t[W-1:0];
        cy  = (ua >= ub);
        st  = sa - sb;
        ovf = (st > m / 2 - 1) || (st < -(m / 2));
      end
      2'b10: begin
        p   = (2*W)'(a) * (2*W)'(b);
        res = p[W-1:0];
        ovf = (p >= (2*W)'(m));
      end
      default: begin
        if (ub == 0) begin
          res = '1;
          ovf = 1'b1;
        end else begin
          t   = ua / ub;
          res = t[W-1:0];
        end
      end
    endcase
    return {res, ovf, cy, (res == '0), res[W-1]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [63:0] r;
    int          mode;
    r    = {$urandom(), $urandom()};
    mode = $urandom_range(0, 4);
    case (mode)
      0: return W'(r[3:0]);                  // small values, including 0
      1: return {W{1'b1}} - W'(r[2:0]);      // near all ones
      2: return {1'b0, {(W-1){1'b1}}} - W'(r[1:0]) + W'(r[2]);  // around the signed boundary
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic test_reset();
    logic [W+3:0] exp_rst;
    exp_rst = {{W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};

    // Operands presented during reset must be discarded.
    rst_n      = 1'b0;
    A          = W'(10);
    B          = W'(5);
    ALUControl = 2'b00;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== exp_rst) begin
      failures++;
      $display("FAIL reset_first_edge: got %h want %h", observed(), exp_rst);
    end

    @(posedge clk);
    #1;
    checks++;
    if (observed() !== exp_rst) begin
      failures++;
      $display("FAIL reset_hold: got %h want %h", observed(), exp_rst);
    end

    // The first valid result appears one edge after rst_n is sampled high.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {W'(15), 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release_add: got %h want %h", observed(),
               {W'(15), 1'b0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_directed();
    // Each row: A, B, op, expected {Result, OverFlow, Carry, Zero, Negative}.
    logic [W-1:0] ta  [13];
    logic [W-1:0] tb  [13];
    logic [1:0]   top [13];
    logic [W+3:0] tex [13];

    ta[0]  = W'(10);            tb[0]  = W'(5);             top[0]  = 2'b00;
    tex[0]  = {W'(15), 4'b0000};
    ta[1]  = W'(20);            tb[1]  = W'(15);            top[1]  = 2'b01;
    tex[1]  = {W'(5), 4'b0100};
    ta[2]  = W'(15);            tb[2]  = W'(20);            top[2]  = 2'b01;
    tex[2]  = {34'h3FFFFFFFB, 4'b0001};
    ta[3]  = W'(4);             tb[3]  = W'(3);             top[3]  = 2'b10;
    tex[3]  = {W'(12), 4'b0000};
    ta[4]  = 34'h200000000;     tb[4]  = W'(2);             top[4]  = 2'b10;
    tex[4]  = {W'(0), 4'b1010};
    ta[5]  = W'(20);            tb[5]  = W'(5);             top[5]  = 2'b11;
    tex[5]  = {W'(4), 4'b0000};
    ta[6]  = W'(50);            tb[6]  = W'(0);             top[6]  = 2'b11;
    tex[6]  = {34'h3FFFFFFFF, 4'b1001};
    ta[7]  = 34'h3FFFFFFFF;     tb[7]  = 34'h3FFFFFFFF;     top[7]  = 2'b00;
    tex[7]  = {34'h3FFFFFFFE, 4'b0101};
    ta[8]  = 34'h1FFFFFFFF;     tb[8]  = 34'h1FFFFFFFF;     top[8]  = 2'b00;
    tex[8]  = {34'h3FFFFFFFE, 4'b1001};
    ta[9]  = W'(5);             tb[9]  = W'(5);             top[9]  = 2'b01;
    tex[9]  = {W'(0), 4'b0110};
    ta[10] = 34'h200000000;     tb[10] = W'(1);             top[10] = 2'b01;
    tex[10] = {34'h1FFFFFFFF, 4'b1100};
    ta[11] = W'(7);             tb[11] = W'(2);             top[11] = 2'b11;
    tex[11] = {W'(3), 4'b0000};
    ta[12] = W'(0);             tb[12] = W'(0);             top[12] = 2'b11;
    tex[12] = {34'h3FFFFFFFF, 4'b1001};

    for (int i = 0; i < 13; i++) begin
      A          = ta[i];
      B          = tb[i];
      ALUControl = top[i];
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== tex[i]) begin
        failures++;
        $display("FAIL directed_%0d: got %h want %h", i, observed(), tex[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W+3:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      A          = rand_operand();
      B          = rand_operand();
      ALUControl = 2'($urandom_range(0, 3));
      exp_v      = model(A, B, ALUControl);
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h want %h",
                 i, ALUControl, A, B, observed(), exp_v);
      end
    end
  endtask

  // A new op every cycle.
  // Changing the inputs must not disturb the registered outputs before the next edge.
  task automatic test_back_to_back();
    logic [W+3:0] prev_v;
    logic [W+3:0] exp_v;

    A          = W'(1);
    B          = W'(1);
    ALUControl = 2'b00;
    prev_v     = model(A, B, ALUControl);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      A          = rand_operand();
      B          = rand_operand();
      ALUControl = 2'(i % 4);
      exp_v      = model(A, B, ALUControl);
      #1;
      checks++;
      if (observed() !== prev_v) begin
        failures++;
        $display("FAIL b2b_hold_%0d: got %h want %h", i, observed(), prev_v);
      end
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL b2b_result_%0d: got %h want %h", i, observed(), exp_v);
      end
      prev_v = exp_v;
    end
  endtask

  task automatic test_midstream_reset();
    logic [W+3:0] exp_v;

    // Produce a nonzero result first, so that a dropped reset cannot go unnoticed.
    A          = 34'h3FFFFFFFF;
    B          = W'(0);
    ALUControl = 2'b11;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {34'h3FFFFFFFF, 4'b1001}) begin
      failures++;
      $display("FAIL mid_pre: got %h want %h", observed(), {34'h3FFFFFFFF, 4'b1001});
    end

    // Reset pulse between edges: the outputs must not move until the edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== {34'h3FFFFFFFF, 4'b1001}) begin
      failures++;
      $display("FAIL mid_no_async: got %h want %h", observed(), {34'h3FFFFFFFF, 4'b1001});
    end

    // Reset overrides the operation pending at this edge.
    A          = W'(9);
    B          = W'(3);
    ALUControl = 2'b10;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {{W{1'b0}}, 4'b0010}) begin
      failures++;
      $display("FAIL mid_reset: got %h want %h", observed(), {{W{1'b0}}, 4'b0010});
    end

    rst_n = 1'b1;
    exp_v = model(A, B, ALUControl);
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== exp_v) begin
      failures++;
      $display("FAIL mid_release: got %h want %h", observed(), exp_v);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    A          = '0;
    B          = '0;
    ALUControl = 2'b00;

    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midstream_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 34, operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk edge.
REQ-004 SHALL have port A, input, WIDTH, first operand.
REQ-005 SHALL have port B, input, WIDTH, second operand.
REQ-006 SHALL have port ALUControl, input, 2, operation select: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have port Result, output, WIDTH, registered operation result.
REQ-008 SHALL have port OverFlow, output, 1, registered overflow / exception flag.
REQ-009 SHALL have port Carry, output, 1, registered carry flag.
REQ-010 SHALL have port Zero, output, 1, registered flag, Result equals 0.
REQ-011 SHALL have port Negative, output, 1, registered flag, copy of Result[WIDTH-1].

Function
REQ-012 SHALL register all outputs; latency exactly 1 cycle: A, B, ALUControl sampled at edge N appear on outputs after edge N.
REQ-013 SHALL accept a new operation every cycle; no handshake, no stall.
REQ-014 Add (00): Result = (A+B) mod 2^WIDTH; Carry = bit WIDTH of unsigned sum; OverFlow = signed overflow (A, B same sign, Result sign differs).
REQ-015 Sub (01): Result = (A-B) mod 2^WIDTH; Carry = 1 when A >= B unsigned (no borrow), else 0; OverFlow = signed overflow (A, B signs differ, Result sign differs from A).
REQ-016 Mul (10): unsigned 2*WIDTH-bit product; Result = low WIDTH bits; OverFlow = 1 when any high WIDTH bit is nonzero; Carry = 0.
REQ-017 Div (11), B != 0: Result = unsigned floor(A/B); remainder discarded; OverFlow = 0; Carry = 0.
REQ-018 Div (11), B == 0: Result = all ones; OverFlow = 1; Carry = 0; no X propagation.
REQ-019 Zero and Negative SHALL derive from the final registered Result for every operation, including divide-by-zero.
REQ-020 Division SHALL complete within the single-cycle latency (combinational datapath before output register).
REQ-021 Outputs SHALL never be X/Z after the first reset cycle for any defined input values.

Reset
REQ-022 When rst_n is low at a rising clk edge, Result SHALL become 0, OverFlow 0, Carry 0, Negative 0, Zero 1.
REQ-023 Reset SHALL take priority over any operation sampled at the same edge; operands presented during reset are discarded.
REQ-024 First valid result after reset deassertion SHALL appear one edge after rst_n is sampled high.
REQ-025 Reset asserted mid-stream SHALL override the pending result on that edge; no asynchronous effect between edges.

Verification
REQ-026 Add: A=10, B=5, ctl=00 -> Result=15, Carry=0, OverFlow=0, Zero=0, Negative=0.
REQ-027 Sub: A=20, B=15, ctl=01 -> Result=5, Carry=1, OverFlow=0, Zero=0, Negative=0; A=15, B=20 -> Result=0x3FFFFFFFB, Carry=0, Negative=1.
REQ-028 Mul: A=4, B=3, ctl=10 -> Result=12, OverFlow=0; A=0x200000000, B=2 -> Result=0, OverFlow=1, Zero=1.
REQ-029 Div: A=20, B=5, ctl=11 -> Result=4; A=50, B=0 -> Result=0x3FFFFFFFF, OverFlow=1, Negative=1, Zero=0.
REQ-030 Add wrap: A=B=0x3FFFFFFFF, ctl=00 -> Result=0x3FFFFFFFE, Carry=1, OverFlow=0, Negative=1; A=B=0x1FFFFFFFF -> OverFlow=1.
REQ-031 Reset: rst_n low for one edge while A=10, B=5, ctl=00 -> outputs at reset values (Zero=1); rst_n high next edge -> Result=15.
